// File: rtl/uart_rx_word.sv
// UART receiver packing BYTE_WIDTH frames little-endian into WORD_WIDTH words; word_valid rises 1 cycle after the final stop sample.
// Output holds until word_valid && word_ready; a word completing while the output is stalled is dropped with an overrun pulse.
module uart_rx_word #(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int CLK_FREQ   = 200_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sig_in,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int NUM_BYTES    = WORD_WIDTH / BYTE_WIDTH;
  localparam int TMR_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int BYTE_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [TMR_W-1:0]  TMR_FULL  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0]  TMR_HALF  = TMR_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BYTE_WIDTH - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_sync_d;
  logic [TMR_W-1:0]      r_timer;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [BYTE_WIDTH-1:0] r_shift;
  logic [BYTE_W-1:0]     r_byte_cnt;
  logic [WORD_WIDTH-1:0] r_accum;
  logic [WORD_WIDTH-1:0] r_word_data;
  logic                  r_word_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic                  w_timer_clr;
  logic                  w_bit_sample;
  logic                  w_stop_ok;
  logic                  w_stop_bad;
  logic                  w_word_done;
  logic [WORD_WIDTH-1:0] w_assembled;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= sig_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Edge detect on the synchronized line only, so a line stuck low never retriggers.
  always_comb begin
    w_next_state = r_state;
    w_timer_clr  = 1'b0;
    w_bit_sample = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_clr = 1'b1;
        if (r_sync_d && !r_sync2) w_next_state = S_START;
      end
      S_START: begin
        if (r_timer == TMR_HALF) begin
          w_timer_clr  = 1'b1;
          w_next_state = r_sync2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_timer == TMR_FULL) begin
          w_timer_clr  = 1'b1;
          w_bit_sample = 1'b1;
          if (r_bit_cnt == BIT_LAST) w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (r_timer == TMR_FULL) begin
          w_timer_clr  = 1'b1;
          w_next_state = S_IDLE;
          w_stop_ok    = r_sync2;
          w_stop_bad   = !r_sync2;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_timer <= w_timer_clr ? '0 : r_timer + 1'b1;
      if (r_state != S_DATA) r_bit_cnt <= '0;
      else if (w_bit_sample) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_bit_sample) r_shift <= {r_sync2, r_shift[BYTE_WIDTH-1:1]};
    end
  end

  always_comb begin
    w_assembled = r_accum;
    w_assembled[WORD_WIDTH-1 -: BYTE_WIDTH] = r_shift;
  end

  assign w_word_done = w_stop_ok && (r_byte_cnt == BYTE_LAST);

  always_ff @(posedge clock) begin
    if (reset || w_stop_bad || w_word_done) begin
      r_byte_cnt <= '0;
      r_accum    <= '0;
    end else if (w_stop_ok) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (r_byte_cnt == BYTE_W'(i)) r_accum[i*BYTE_WIDTH +: BYTE_WIDTH] <= r_shift;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_data  <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_stop_bad;
      r_overrun   <= 1'b0;
      if (w_word_done) begin
        if (!r_word_valid || word_ready) begin
          r_word_data  <= w_assembled;
          r_word_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_word_valid && word_ready) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign word_data  = r_word_data;
  assign word_valid = r_word_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit; a negedge monitor logs accepted words and pulse cycles.
module tb_uart_rx_word;

  localparam int BIT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        sig_in;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_err;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int          mon_words = 0;
  int          mon_fe    = 0;
  int          mon_ov    = 0;
  int          mon_vcyc  = 0;
  logic [31:0] rx_word [0:63];

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  uart_rx_word #(
    .WORD_WIDTH(32),
    .BYTE_WIDTH(8),
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sig_in    (sig_in),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (word_valid && word_ready) begin
        if (mon_words < 64) rx_word[mon_words] = word_data;
        mon_words++;
      end
      if (word_valid) mon_vcyc++;
      if (frame_err)  mon_fe++;
      if (overrun)    mon_ov++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < mon_words && idx < 64) return rx_word[idx];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    tick();
    sig_in = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      sig_in = d[i];
      repeat (BIT) tick();
    end
    sig_in = stop_bit;
    repeat (BIT) tick();
    sig_in = 1'b1;
    repeat (BIT) tick();
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  initial begin
    int base_w, base_fe, base_ov, base_vc;

    vecs[0] = '{b0: 8'h03, b1: 8'h04, b2: 8'hAA, b3: 8'hFF, exp: 32'hFFAA0403};
    vecs[1] = '{b0: 8'h00, b1: 8'h00, b2: 8'h00, b3: 8'h00, exp: 32'h00000000};
    vecs[2] = '{b0: 8'hFF, b1: 8'hFF, b2: 8'hFF, b3: 8'hFF, exp: 32'hFFFFFFFF};
    vecs[3] = '{b0: 8'h55, b1: 8'hAA, b2: 8'h0F, b3: 8'hF0, exp: 32'hF00FAA55};
    vecs[4] = '{b0: 8'h12, b1: 8'h34, b2: 8'h56, b3: 8'h78, exp: 32'h78563412};

    reset = 1'b1;
    sig_in = 1'b1;
    word_ready = 1'b0;
    repeat (4) tick();
    check("reset word_data", word_data, 32'h0);
    check("reset word_valid", {31'd0, word_valid}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    repeat (BIT) tick();

    // Table: one word each with consumer always ready.
    word_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      base_w = mon_words; base_fe = mon_fe; base_ov = mon_ov; base_vc = mon_vcyc;
      send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      repeat (4) tick();
      check($sformatf("vec%0d word", v), rx_at(base_w), vecs[v].exp);
      check($sformatf("vec%0d word count", v), mon_words - base_w, 1);
      check($sformatf("vec%0d valid cycles", v), mon_vcyc - base_vc, 1);
      check($sformatf("vec%0d error pulses", v), (mon_fe - base_fe) + (mon_ov - base_ov), 0);
    end

    // Stalled consumer: second word is dropped with one overrun pulse.
    word_ready = 1'b0;
    base_w = mon_words; base_ov = mon_ov;
    send_word(8'h03, 8'h04, 8'hAA, 8'hFF);
    check("stall first word_data", word_data, 32'hFFAA0403);
    check("stall valid held", {31'd0, word_valid}, 32'd1);
    send_word(8'hBB, 8'hCC, 8'hDD, 8'hEE);
    check("overrun word_data kept", word_data, 32'hFFAA0403);
    check("overrun pulses", mon_ov - base_ov, 1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    tick();
    check("overrun drained word", rx_at(base_w), 32'hFFAA0403);
    check("overrun valid dropped", {31'd0, word_valid}, 32'd0);
    check("overrun word count", mon_words - base_w, 1);

    // Completion in the exact handshake cycle replaces the word without overrun.
    base_w = mon_words; base_ov = mon_ov;
    send_word(8'h11, 8'h22, 8'h33, 8'h44);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    fork
      send_byte(8'h88, 1'b1);
      begin
        tick();
        repeat (154) tick();
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
      end
    join
    check("same-cycle old word taken", rx_at(base_w), 32'h44332211);
    check("same-cycle new word_data", word_data, 32'h88776655);
    check("same-cycle valid high", {31'd0, word_valid}, 32'd1);
    check("same-cycle no overrun", mon_ov - base_ov, 0);
    word_ready = 1'b1;
    repeat (2) tick();
    check("same-cycle second word", rx_at(base_w + 1), 32'h88776655);

    // Frame error on the second byte discards the partial word.
    base_w = mon_words; base_fe = mon_fe; base_ov = mon_ov;
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b0);
    check("frame_err pulses", mon_fe - base_fe, 1);
    send_word(8'hBB, 8'hCC, 8'hDD, 8'hEE);
    repeat (4) tick();
    check("after frame_err word", rx_at(base_w), 32'hEEDDCCBB);
    check("after frame_err count", mon_words - base_w, 1);

    // Short low glitch is a false start.
    base_w = mon_words; base_fe = mon_fe; base_ov = mon_ov;
    tick();
    sig_in = 1'b0;
    repeat (5) tick();
    sig_in = 1'b1;
    repeat (3 * BIT) tick();
    check("glitch no word", mon_words - base_w, 0);
    check("glitch no pulses", (mon_fe - base_fe) + (mon_ov - base_ov), 0);
    send_word(8'h03, 8'h04, 8'hAA, 8'hFF);
    repeat (4) tick();
    check("glitch then word", rx_at(base_w), 32'hFFAA0403);

    // Reset during bit 3 clears held word and partial assembly.
    word_ready = 1'b0;
    send_word(8'h12, 8'h34, 8'h56, 8'h78);
    send_byte(8'h11, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        tick();
        repeat (70) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
      end
    join
    check("midreset word_data", word_data, 32'h0);
    check("midreset word_valid", {31'd0, word_valid}, 32'd0);
    check("midreset pulses", {30'd0, overrun, frame_err}, 32'd0);
    word_ready = 1'b1;
    base_w = mon_words;
    send_word(8'h03, 8'h04, 8'hAA, 8'hFF);
    repeat (4) tick();
    check("after reset word", rx_at(base_w), 32'hFFAA0403);
    check("after reset count", mon_words - base_w, 1);

    // Back-to-back stream with consumer always ready.
    base_w = mon_words; base_ov = mon_ov; base_vc = mon_vcyc;
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    send_word(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    send_word(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    repeat (4) tick();
    check("stream word0", rx_at(base_w), 32'h04030201);
    check("stream word1", rx_at(base_w + 1), 32'hD4C3B2A1);
    check("stream word2", rx_at(base_w + 2), 32'hEFBEADDE);
    check("stream valid cycles", mon_vcyc - base_vc, 3);
    check("stream no overrun", mon_ov - base_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
